// File: rtl/axi_ram_responder_pkg.sv
// Shared types for the AXI3 RAM responder: FSM states,
// burst and response encodings, WRAP length helper.
package axi_ram_responder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        BRESP = 2'd2,
        READ  = 2'd3
    } state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats
    function automatic logic wrap_len_ok(input logic [3:0] len);
        return (len == 4'd1) || (len == 4'd3) ||
               (len == 4'd7) || (len == 4'd15);
    endfunction

endpackage

// File: rtl/axi_ram_responder_mem.sv
// Single-port word RAM with byte enables and a registered,
// enable-gated read port (output holds when not enabled).
module axi_ram_responder_mem #(
    parameter int MEM_WORDS_LOG2 = 12
) (
    input  logic                      i_clk,
    input  logic                      i_en,
    input  logic [3:0]                i_we,
    input  logic [MEM_WORDS_LOG2-1:0] i_addr,
    input  logic [31:0]               i_wdata,
    output logic [31:0]               o_rdata
);

    logic [31:0] r_mem [0:(1<<MEM_WORDS_LOG2)-1];
    logic [31:0] r_rdata;

    // byte-masked write and enabled synchronous read
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we[b]) begin
                r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
        if (i_en) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_ram_responder.sv
// AXI3 RAM responder, one transaction in flight, 32-bit data.
// Define AXI_RAM_RESPONDER_WRAP_EN to enable WRAP bursts.
module axi_ram_responder
    import axi_ram_responder_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int ID_WIDTH       = 4,
    parameter int MEM_WORDS_LOG2 = 12
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [ID_WIDTH-1:0]   awid,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [3:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wstrb,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [ID_WIDTH-1:0]   bid,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [3:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [ID_WIDTH-1:0]   rid,
    output logic [31:0]           rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready
);

`ifdef AXI_RAM_RESPONDER_WRAP_EN
    localparam logic WRAP_ON = 1'b1;
`else
    localparam logic WRAP_ON = 1'b0;
`endif

    state_t r_state;
    state_t w_next;

    logic [ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [3:0]            r_len;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic                  r_err;
    logic                  r_prio_rd;

    logic [3:0]            r_wcnt;
    logic                  r_werr;
    logic [1:0]            r_bresp;

    logic [4:0]            r_irem;
    logic [3:0]            r_ocnt;
    logic                  r_mem_vld;
    logic                  r_rvalid;
    logic                  r_rlast;
    logic [31:0]           r_rdata;
    logic [1:0]            r_rresp;

    logic                  w_gnt_rd;
    logic                  w_gnt_wr;
    logic                  w_wbeat;
    logic                  w_wfinal;
    logic                  w_beat_err;
    logic                  w_load;
    logic                  w_ren;
    logic [3:0]            w_mem_we;
    logic [31:0]           w_mem_rdata;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic [MEM_WORDS_LOG2-1:0] w_mem_addr;

    // Unsupported size, reserved burst or unusable WRAP
    function automatic logic req_err(
        input logic [2:0] size,
        input logic [1:0] burst,
        input logic [3:0] len
    );
        logic w_bad;
        w_bad = (size > 3'd2) || (burst == 2'b11);
        if (burst == BURST_WRAP) begin
            w_bad = w_bad || !(WRAP_ON && wrap_len_ok(len));
        end
        return w_bad;
    endfunction

    // Beat-to-beat address step for FIXED/INCR/WRAP
    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [2:0]            size,
        input logic [1:0]            burst,
        input logic [3:0]            len
    );
        logic [ADDR_WIDTH-1:0] w_sum;
        logic [ADDR_WIDTH-1:0] w_mask;
        logic [ADDR_WIDTH-1:0] w_res;
        w_sum  = addr + (ADDR_WIDTH'(1) << size);
        w_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size)
                 - ADDR_WIDTH'(1);
        w_res  = addr;
        case (burst)
            BURST_INCR: w_res = w_sum;
            BURST_WRAP: begin
                if (WRAP_ON) begin
                    w_res = (addr & ~w_mask) | (w_sum & w_mask);
                end
            end
            default:    w_res = addr;
        endcase
        return w_res;
    endfunction

    assign w_next_addr = next_addr(r_addr, r_size, r_burst, r_len);
    assign w_mem_addr  = r_addr[MEM_WORDS_LOG2+1:2];

    assign w_wbeat    = (r_state == WRITE) && wvalid;
    assign w_wfinal   = (r_wcnt == r_len);
    assign w_beat_err = (wlast != w_wfinal);
    assign w_mem_we   = (w_wbeat && !r_err) ? wstrb : 4'h0;

    assign w_load = (r_state == READ) && r_mem_vld &&
                    (!r_rvalid || rready);
    assign w_ren  = (r_state == READ) && (r_irem != 5'd0) &&
                    (!r_mem_vld || w_load);

    axi_ram_responder_mem #(
        .MEM_WORDS_LOG2(MEM_WORDS_LOG2)
    ) u_mem (
        .i_clk   (aclk),
        .i_en    (w_ren),
        .i_we    (w_mem_we),
        .i_addr  (w_mem_addr),
        .i_wdata (wdata),
        .o_rdata (w_mem_rdata)
    );

    // FSM state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, arbitration and channel ready/valid
    always_comb begin
        w_next   = r_state;
        w_gnt_rd = 1'b0;
        w_gnt_wr = 1'b0;
        awready  = 1'b0;
        arready  = 1'b0;
        wready   = 1'b0;
        bvalid   = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_gnt_rd = arvalid && (!awvalid || r_prio_rd);
                w_gnt_wr = awvalid && !w_gnt_rd;
                arready  = w_gnt_rd;
                awready  = w_gnt_wr;
                if (w_gnt_rd) begin
                    w_next = READ;
                end else if (w_gnt_wr) begin
                    w_next = WRITE;
                end
            end
            WRITE: begin
                wready = 1'b1;
                if (wvalid && w_wfinal) begin
                    w_next = BRESP;
                end
            end
            BRESP: begin
                bvalid = 1'b1;
                if (bready) begin
                    w_next = IDLE;
                end
            end
            READ: begin
                if (r_rvalid && rready && r_rlast) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Request capture, priority toggle and address walk
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_id      <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_size    <= '0;
            r_burst   <= '0;
            r_err     <= 1'b0;
            r_prio_rd <= 1'b1;
        end else if (w_gnt_rd) begin
            r_id      <= arid;
            r_addr    <= araddr;
            r_len     <= arlen;
            r_size    <= arsize;
            r_burst   <= arburst;
            r_err     <= req_err(arsize, arburst, arlen);
            r_prio_rd <= 1'b0;
        end else if (w_gnt_wr) begin
            r_id      <= awid;
            r_addr    <= awaddr;
            r_len     <= awlen;
            r_size    <= awsize;
            r_burst   <= awburst;
            r_err     <= req_err(awsize, awburst, awlen);
            r_prio_rd <= 1'b1;
        end else if (w_wbeat || w_ren) begin
            r_addr    <= w_next_addr;
        end
    end

    // Write beat counting and response code
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wcnt  <= '0;
            r_werr  <= 1'b0;
            r_bresp <= RESP_OKAY;
        end else if (w_gnt_wr) begin
            r_wcnt  <= '0;
            r_werr  <= 1'b0;
        end else if (w_wbeat) begin
            r_wcnt <= r_wcnt + 4'd1;
            if (w_beat_err) begin
                r_werr <= 1'b1;
            end
            if (w_wfinal) begin
                r_bresp <= (r_err || r_werr || w_beat_err) ?
                           RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // Read pipeline: RAM fetch then output register with stall
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_irem    <= '0;
            r_ocnt    <= '0;
            r_mem_vld <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            if (w_gnt_rd) begin
                r_irem <= {1'b0, arlen} + 5'd1;
                r_ocnt <= '0;
            end else if (w_ren) begin
                r_irem <= r_irem - 5'd1;
            end
            if (w_ren) begin
                r_mem_vld <= 1'b1;
            end else if (w_load) begin
                r_mem_vld <= 1'b0;
            end
            if (w_load) begin
                r_rvalid <= 1'b1;
                r_rdata  <= r_err ? 32'h0 : w_mem_rdata;
                r_rresp  <= r_err ? RESP_SLVERR : RESP_OKAY;
                r_rlast  <= (r_ocnt == r_len);
                r_ocnt   <= r_ocnt + 4'd1;
            end else if (r_rvalid && rready) begin
                r_rvalid <= 1'b0;
                r_rlast  <= 1'b0;
            end
        end
    end

    assign bid    = r_id;
    assign bresp  = r_bresp;
    assign rid    = r_id;
    assign rdata  = r_rdata;
    assign rresp  = r_rresp;
    assign rlast  = r_rlast;
    assign rvalid = r_rvalid;

endmodule

// File: tb/tb_axi_ram_responder.sv
// Directed, table-driven bench for axi_ram_responder.
// WRAP expectations follow AXI_RAM_RESPONDER_WRAP_EN.
module tb_axi_ram_responder;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [3:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [3:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [3:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [3:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;

    always #5 aclk = ~aclk;

    axi_ram_responder dut (
        .aclk(aclk), .aresetn(aresetn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid),
        .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [31:0] d0;
        logic [3:0]  strb;
        bit          wlerr;
        logic [1:0]  resp;
        logic [31:0] e0;
        logic [31:0] estep;
    } vec_t;

    localparam int NV = 20;
    vec_t        tbl [NV];
    logic [31:0] r_exp [16];
    bit          pat [4];
    int          plen = 1;
    int          pass_cnt = 0;
    int          tot_cnt = 0;
    string       tag = "";

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s %s: got %h expected %h",
                      tag, nm, act, exp);
    endtask

    task automatic chk1(input string nm, input logic act,
                        input logic exp);
        chk(nm, 32'(act), 32'(exp));
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [31:0] a,
                           input logic [3:0] l, input logic [2:0] s,
                           input logic [1:0] b);
        int n = 0;
        @(negedge aclk);
        awid = id; awaddr = a; awlen = l; awsize = s; awburst = b;
        awvalid = 1'b1;
        #1;
        while (!awready && n < 50) begin
            @(negedge aclk); #1; n++;
        end
        chk1("awready timeout", n < 50, 1'b1);
        @(negedge aclk);
        awvalid = 1'b0;
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] a,
                           input logic [3:0] l, input logic [2:0] s,
                           input logic [1:0] b);
        int n = 0;
        @(negedge aclk);
        arid = id; araddr = a; arlen = l; arsize = s; arburst = b;
        arvalid = 1'b1;
        #1;
        while (!arready && n < 50) begin
            @(negedge aclk); #1; n++;
        end
        chk1("arready timeout", n < 50, 1'b1);
        @(negedge aclk);
        arvalid = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] d0, input logic [3:0] strb,
                          input logic [3:0] l, input bit wl_err);
        int n;
        for (int i = 0; i <= int'(l); i++) begin
            n = 0;
            @(negedge aclk);
            wdata  = d0 + 32'(i);
            wstrb  = strb;
            wlast  = (i == int'(l)) ^ (wl_err && i == 0);
            wvalid = 1'b1;
            #1;
            while (!wready && n < 50) begin
                @(negedge aclk); #1; n++;
            end
            chk1("wready timeout", n < 50, 1'b1);
        end
        @(negedge aclk);
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    task automatic b_get(input logic [1:0] er, input logic [3:0] eid);
        int n = 0;
        bready = 1'b1;
        while (!bvalid && n < 50) begin
            @(negedge aclk); n++;
        end
        chk1("bvalid timeout", n < 50, 1'b1);
        chk("bresp", 32'(bresp), 32'(er));
        chk("bid", 32'(bid), 32'(eid));
        @(negedge aclk);
        bready = 1'b0;
        chk1("bvalid after", bvalid, 1'b0);
    endtask

    task automatic r_get(input int nb, input logic [1:0] er,
                         input logic [3:0] eid, input bit lat);
        int          cnt = 0;
        int          got = 0;
        int          k = 0;
        int          nlast = 0;
        bit          hold = 0;
        logic [31:0] hold_d = '0;
        if (lat) begin
            while (!rvalid && cnt < 50) begin
                @(negedge aclk); cnt++;
            end
            chk("first beat latency", 32'(cnt), 32'd2);
        end
        cnt = 0;
        while (got < nb && cnt < 200) begin
            if (hold) begin
                chk1("stall rvalid", rvalid, 1'b1);
                chk("stall rdata", rdata, hold_d);
                hold = 0;
            end
            rready = pat[k % plen];
            k++;
            if (rvalid && rready) begin
                chk($sformatf("rdata beat%0d", got), rdata, r_exp[got]);
                chk("rresp", 32'(rresp), 32'(er));
                chk1("rlast", rlast, got == nb - 1);
                if (got == 0) chk("rid", 32'(rid), 32'(eid));
                if (rlast) nlast++;
                got++;
            end else if (rvalid) begin
                hold   = 1;
                hold_d = rdata;
            end
            @(negedge aclk);
            cnt++;
        end
        rready = 1'b0;
        chk("beat count", 32'(got), 32'(nb));
        chk("rlast count", 32'(nlast), 32'd1);
        chk1("rvalid after", rvalid, 1'b0);
    endtask

    task automatic chk_zero_outputs();
        chk1("rst awready", awready, 1'b0);
        chk1("rst wready", wready, 1'b0);
        chk1("rst bvalid", bvalid, 1'b0);
        chk1("rst arready", arready, 1'b0);
        chk1("rst rvalid", rvalid, 1'b0);
        chk1("rst rlast", rlast, 1'b0);
        chk("rst bid", 32'(bid), 32'd0);
        chk("rst rid", 32'(rid), 32'd0);
        chk("rst bresp", 32'(bresp), 32'd0);
        chk("rst rresp", 32'(rresp), 32'd0);
        chk("rst rdata", rdata, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        pat[0] = 1'b1; pat[1] = 1'b1; pat[2] = 1'b1; pat[3] = 1'b1;
        //          wr addr      len  sz burst  d0         strb wle resp  e0   step
        tbl[0]  = '{1, 32'h10,  3, 2, 2'b01, 32'hA0,     4'hF, 0, 2'b00, 0, 0};
        tbl[1]  = '{0, 32'h10,  3, 2, 2'b01, 0,          4'h0, 0, 2'b00, 32'hA0, 1};
        tbl[2]  = '{1, 32'h20,  0, 2, 2'b01, 32'hFFFFFFFF, 4'hF, 0, 2'b00, 0, 0};
        tbl[3]  = '{1, 32'h20,  0, 2, 2'b01, 32'h0,      4'h2, 0, 2'b00, 0, 0};
        tbl[4]  = '{0, 32'h20,  0, 2, 2'b01, 0,          4'h0, 0, 2'b00, 32'hFFFF00FF, 0};
        tbl[5]  = '{0, 32'h11,  0, 0, 2'b01, 0,          4'h0, 0, 2'b00, 32'hA0, 0};
        tbl[6]  = '{0, 32'h10,  2, 2, 2'b00, 0,          4'h0, 0, 2'b00, 32'hA0, 0};
        tbl[7]  = '{0, 32'h10,  1, 3, 2'b01, 0,          4'h0, 0, 2'b10, 0, 0};
        tbl[8]  = '{0, 32'h10,  1, 2, 2'b11, 0,          4'h0, 0, 2'b10, 0, 0};
        tbl[9]  = '{1, 32'h10,  0, 3, 2'b01, 32'hDEADBEEF, 4'hF, 0, 2'b10, 0, 0};
        tbl[10] = '{1, 32'h14,  0, 2, 2'b11, 32'hDEADBEEF, 4'hF, 0, 2'b10, 0, 0};
        tbl[11] = '{0, 32'h10,  1, 2, 2'b01, 0,          4'h0, 0, 2'b00, 32'hA0, 1};
        tbl[12] = '{1, 32'h60,  1, 2, 2'b01, 32'h60,     4'hF, 1, 2'b10, 0, 0};
        tbl[13] = '{0, 32'h60,  1, 2, 2'b01, 0,          4'h0, 0, 2'b00, 32'h60, 1};
        tbl[14] = '{1, 32'h100, 15, 2, 2'b01, 32'h100,   4'hF, 0, 2'b00, 0, 0};
        tbl[15] = '{0, 32'h100, 15, 2, 2'b01, 0,         4'h0, 0, 2'b00, 32'h100, 1};
        tbl[16] = '{1, 32'h30,  3, 2, 2'b01, 32'hC0,     4'hF, 0, 2'b00, 0, 0};
        tbl[17] = '{1, 32'h40,  2, 2, 2'b00, 32'h40,     4'hF, 0, 2'b00, 0, 0};
        tbl[18] = '{0, 32'h40,  0, 2, 2'b01, 0,          4'h0, 0, 2'b00, 32'h42, 0};
        tbl[19] = '{0, 32'h30,  2, 2, 2'b10, 0,          4'h0, 0, 2'b10, 0, 0};

        tag = "reset";
        #12;
        chk_zero_outputs();
        @(negedge aclk);
        aresetn = 1'b1;

        for (int i = 0; i < NV; i++) begin
            v   = tbl[i];
            tag = $sformatf("vec%0d", i);
            if (v.wr) begin
                aw_send(4'(i), v.addr, v.len, v.size, v.burst);
                w_send(v.d0, v.strb, v.len, v.wlerr);
                b_get(v.resp, 4'(i));
            end else begin
                for (int j = 0; j <= int'(v.len); j++) begin
                    r_exp[j] = v.e0 + 32'(j) * v.estep;
                end
                ar_send(4'(i), v.addr, v.len, v.size, v.burst);
                r_get(int'(v.len) + 1, v.resp, 4'(i), 1'b1);
            end
        end

        tag = "wrap";
`ifdef AXI_RAM_RESPONDER_WRAP_EN
        r_exp[0] = 32'hC2; r_exp[1] = 32'hC3;
        r_exp[2] = 32'hC0; r_exp[3] = 32'hC1;
        ar_send(4'd9, 32'h38, 4'd3, 3'd2, 2'b10);
        r_get(4, 2'b00, 4'd9, 1'b1);
`else
        for (int j = 0; j < 4; j++) r_exp[j] = 32'h0;
        ar_send(4'd9, 32'h38, 4'd3, 3'd2, 2'b10);
        r_get(4, 2'b10, 4'd9, 1'b1);
`endif

        tag = "stall";
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        plen = 4;
        for (int j = 0; j < 8; j++) r_exp[j] = 32'h100 + 32'(j);
        ar_send(4'd10, 32'h100, 4'd7, 3'd2, 2'b01);
        r_get(8, 2'b00, 4'd10, 1'b1);
        plen = 1;
        pat[0] = 1'b1;

        tag = "abort";
        aw_send(4'd3, 32'h80, 4'd3, 3'd2, 2'b01);
        @(negedge aclk);
        wdata = 32'h99; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
        #1;
        chk1("beat1 wready", wready, 1'b1);
        @(negedge aclk);
        wdata = 32'h9A;
        #2;
        aresetn = 1'b0;
        #1;
        chk_zero_outputs();
        wvalid = 1'b0;
        repeat (2) @(negedge aclk);
        chk1("held wready", wready, 1'b0);
        aresetn = 1'b1;

        tag = "grant";
        @(negedge aclk);
        arid = 4'd5; araddr = 32'h10; arlen = 4'd3;
        arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        awid = 4'd6; awaddr = 32'h200; awlen = 4'd0;
        awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
        #1;
        chk1("first arready", arready, 1'b1);
        chk1("first awready", awready, 1'b0);
        @(negedge aclk);
        arvalid = 1'b0;
        awvalid = 1'b0;
        for (int j = 0; j < 4; j++) r_exp[j] = 32'hA0 + 32'(j);
        r_get(4, 2'b00, 4'd5, 1'b1);
        arid = 4'd7; araddr = 32'h10; arlen = 4'd0;
        arvalid = 1'b1;
        awvalid = 1'b1;
        #1;
        chk1("second awready", awready, 1'b1);
        chk1("second arready", arready, 1'b0);
        @(negedge aclk);
        awvalid = 1'b0;
        #1;
        chk1("busy arready", arready, 1'b0);
        w_send(32'h77, 4'hF, 4'd0, 1'b0);
        b_get(2'b00, 4'd6);
        begin
            int n = 0;
            #1;
            while (!arready && n < 50) begin
                @(negedge aclk); #1; n++;
            end
            chk1("late arready timeout", n < 50, 1'b1);
        end
        @(negedge aclk);
        arvalid = 1'b0;
        r_exp[0] = 32'hA0;
        r_get(1, 2'b00, 4'd7, 1'b1);
        r_exp[0] = 32'h77;
        ar_send(4'd8, 32'h200, 4'd0, 3'd2, 2'b01);
        r_get(1, 2'b00, 4'd8, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
